// File: rtl/resp_formatter_if.sv
// Bundle of the signals between the command parser, the reply formatter and
// the UART transmitter. The master side raises requests and drives tx_ready.
// The slave side is the formatter, which offers bytes and reports status.
interface resp_formatter_if;
  logic [15:0] display_val;
  logic        update_display;
  logic        show_error;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overrun;

  modport master (
    output display_val, update_display, show_error, tx_ready,
    input  tx_data, tx_valid, busy, overrun
  );

  modport slave (
    input  display_val, update_display, show_error, tx_ready,
    output tx_data, tx_valid, busy, overrun
  );
endinterface

// File: rtl/resp_formatter.sv
// Reply formatter: turns value-update and error pulses into ASCII frames,
// one byte at a time, for the UART transmitter.
// Value frame: prefix, five decimal digits, optional CR LF.
// Error frame: "ERR", optional CR LF.
// A binary-to-BCD conversion takes one shift per clock. One value request
// and one error request can wait while a frame is being converted or sent.
module resp_formatter #(
  parameter logic [7:0] VAL_PREFIX = 8'h56,
  parameter bit         SEND_CRLF  = 1'b1
) (
  input logic             clk,
  input logic             reset_n,
  resp_formatter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, SEND_VAL, SEND_ERR} state_t;

  localparam logic [2:0] VAL_LAST  = SEND_CRLF ? 3'd7 : 3'd5;
  localparam logic [2:0] ERR_LAST  = SEND_CRLF ? 3'd4 : 3'd2;
  localparam logic [4:0] CONV_DONE = 5'd16;

  state_t      state_q, state_d;
  logic        pend_val_q, pend_val_d;
  logic        pend_err_q, pend_err_d;
  logic [15:0] pend_value_q, pend_value_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        overrun_q, overrun_d;

  logic        transfer;
  logic        req_err;
  logic        req_val;
  logic [18:0] bcd_adj;
  logic [19:0] bcd_shift;
  logic [15:0] bin_shift;

  assign transfer = tx_valid_q && bus.tx_ready;
  assign req_err  = bus.show_error || pend_err_q;
  assign req_val  = bus.update_display || pend_val_q;

  // Double-dabble correction: add 3 to each low digit that is 5 or more
  // before it is shifted. The top digit never reaches 5 before a shift,
  // because the largest result is 65535, so it passes through unchanged.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
    end
  endgenerate
  assign bcd_adj[18:16] = bcd_q[18:16];
  assign bcd_shift      = {bcd_adj, bin_q[15]};
  assign bin_shift      = {bin_q[14:0], 1'b0};

  // Byte of a value frame at position idx.
  function automatic logic [7:0] val_byte(input logic [2:0] idx, input logic [19:0] bcd);
    logic [7:0] b;
    case (idx)
      3'd0:    b = VAL_PREFIX;
      3'd1:    b = {4'h3, bcd[19:16]};
      3'd2:    b = {4'h3, bcd[15:12]};
      3'd3:    b = {4'h3, bcd[11:8]};
      3'd4:    b = {4'h3, bcd[7:4]};
      3'd5:    b = {4'h3, bcd[3:0]};
      3'd6:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  // Byte of an error frame at position idx.
  function automatic logic [7:0] err_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h45;
      3'd1:    b = 8'h52;
      3'd2:    b = 8'h52;
      3'd3:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_val_q   <= 1'b0;
      pend_err_q   <= 1'b0;
      pend_value_q <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_val_q   <= pend_val_d;
      pend_err_q   <= pend_err_d;
      pend_value_q <= pend_value_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next state: errors win over values; a frame ends when its last byte transfers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_err)      state_d = SEND_ERR;
        else if (req_val) state_d = CONV;
      end
      CONV: begin
        if (cnt_q == CONV_DONE) state_d = SEND_VAL;
      end
      SEND_VAL: begin
        if (transfer && (idx_q == VAL_LAST)) state_d = IDLE;
      end
      SEND_ERR: begin
        if (transfer && (idx_q == ERR_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs: request queuing, BCD conversion and byte sequencing.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_err_d   = pend_err_q;
    pend_value_d = pend_value_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    overrun_d    = 1'b0;

    if (state_q == IDLE) begin
      if (req_err) begin
        // The error frame starts now; a coincident update waits its turn.
        pend_err_d = 1'b0;
        tx_valid_d = 1'b1;
        tx_data_d  = err_byte(3'd0);
        idx_d      = 3'd0;
        if (bus.update_display) begin
          pend_value_d = bus.display_val;
          pend_val_d   = 1'b1;
          overrun_d    = pend_val_q;
        end
      end else if (req_val) begin
        bcd_d = '0;
        cnt_d = '0;
        if (pend_val_q) begin
          // Serve the older stored value first; a fresh update takes its slot.
          bin_d      = pend_value_q;
          pend_val_d = bus.update_display;
          if (bus.update_display) pend_value_d = bus.display_val;
        end else begin
          bin_d = bus.display_val;
        end
      end
    end else begin
      // Requests arriving while busy are held, one per type.
      if (bus.update_display) begin
        pend_value_d = bus.display_val;
        pend_val_d   = 1'b1;
      end
      if (bus.show_error) pend_err_d = 1'b1;
      overrun_d = (bus.update_display && pend_val_q) || (bus.show_error && pend_err_q);

      case (state_q)
        CONV: begin
          if (cnt_q == CONV_DONE) begin
            tx_valid_d = 1'b1;
            tx_data_d  = VAL_PREFIX;
            idx_d      = 3'd0;
          end else begin
            bcd_d = bcd_shift;
            bin_d = bin_shift;
            cnt_d = cnt_q + 5'd1;
          end
        end
        SEND_VAL: begin
          if (transfer) begin
            if (idx_q == VAL_LAST) begin
              tx_valid_d = 1'b0;
              tx_data_d  = '0;
              idx_d      = '0;
            end else begin
              idx_d     = idx_q + 3'd1;
              tx_data_d = val_byte(idx_q + 3'd1, bcd_q);
            end
          end
        end
        SEND_ERR: begin
          if (transfer) begin
            if (idx_q == ERR_LAST) begin
              tx_valid_d = 1'b0;
              tx_data_d  = '0;
              idx_d      = '0;
            end else begin
              idx_d     = idx_q + 3'd1;
              tx_data_d = err_byte(idx_q + 3'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_resp_formatter.sv
// Directed bench for resp_formatter: one DUT with CR/LF enabled and one
// without, both on the same clock and reset.
module tb_resp_formatter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  resp_formatter_if ifa ();
  resp_formatter_if ifb ();

  resp_formatter #(.VAL_PREFIX(8'h56), .SEND_CRLF(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
  );
  resp_formatter #(.VAL_PREFIX(8'h56), .SEND_CRLF(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] cap [0:7];
  int got, viol, ovr_cnt, first_cyc, last_cyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rd_valid(input int sel);
    return (sel == 0) ? ifa.tx_valid : ifb.tx_valid;
  endfunction
  function automatic logic [7:0] rd_data(input int sel);
    return (sel == 0) ? ifa.tx_data : ifb.tx_data;
  endfunction
  function automatic logic rd_over(input int sel);
    return (sel == 0) ? ifa.overrun : ifb.overrun;
  endfunction

  task automatic set_ready(input int sel, input logic r);
    if (sel == 0) ifa.tx_ready = r;
    else          ifb.tx_ready = r;
  endtask

  // Receive up to n bytes, acting as the UART transmitter. mode 0 holds
  // tx_ready high; mode 1 raises it one cycle in three. Records captured bytes,
  // hold violations while stalled, and overrun pulses seen.
  task automatic collect(input int sel, input int n, input int mode, input int budget);
    logic       pend_prev;
    logic [7:0] data_prev;
    logic       r;
    got = 0; viol = 0; ovr_cnt = 0; first_cyc = -1; last_cyc = -1;
    pend_prev = 1'b0; data_prev = '0;
    for (int cyc = 0; cyc < budget && got < n; cyc++) begin
      if (rd_over(sel)) ovr_cnt++;
      if (pend_prev && (!rd_valid(sel) || rd_data(sel) !== data_prev)) viol++;
      r = (mode == 0) ? 1'b1 : ((cyc % 3 == 2) ? 1'b1 : 1'b0);
      set_ready(sel, r);
      if (rd_valid(sel) && r) begin
        cap[got] = rd_data(sel);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        $display("  dut%0d byte %0d = %02h (cycle %0d)", sel, got, rd_data(sel), cyc);
        got++;
        pend_prev = 1'b0;
      end else begin
        pend_prev = rd_valid(sel);
        data_prev = rd_data(sel);
      end
      step();
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (ifa.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_a: got %b expected 0", ifa.tx_valid); end
    checks++; if (ifa.tx_data !== 8'h00) begin errors++; $display("FAIL rst_data_a: got %02h expected 00", ifa.tx_data); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_busy_a: got %b expected 0", ifa.busy); end
    checks++; if (ifa.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun_a: got %b expected 0", ifa.overrun); end
    checks++; if (ifb.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_b: got %b expected 0", ifb.tx_valid); end
    checks++; if (ifb.busy !== 1'b0) begin errors++; $display("FAIL rst_busy_b: got %b expected 0", ifb.busy); end
    #3 reset_n = 1'b1;
    step();
    $display("reset released");
  endtask

  task automatic test_value_latency();
    logic [7:0] exp_v [0:7];
    exp_v = '{8'h56, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    ifa.tx_ready = 1'b1;
    ifa.display_val = 16'd1234; ifa.update_display = 1'b1;
    step();
    ifa.update_display = 1'b0;
    repeat (16) step();
    checks++; if (ifa.tx_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_early: got %b expected 0 at edge 16", ifa.tx_valid); end
    checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL t1_busy_conv: got %b expected 1", ifa.busy); end
    step();
    checks++; if (ifa.tx_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_17: got %b expected 1 at edge 17", ifa.tx_valid); end
    checks++; if (ifa.tx_data !== 8'h56) begin errors++; $display("FAIL t1_first_byte: got %02h expected 56", ifa.tx_data); end
    collect(0, 8, 0, 20);
    checks++; if (got !== 8) begin errors++; $display("FAIL t1_count: got %0d expected 8", got); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL t1_byte%0d: got %02h expected %02h", i, cap[i], exp_v[i]); end
    end
    checks++; if (last_cyc - first_cyc !== 7) begin errors++; $display("FAIL t1_back_to_back: span %0d expected 7", last_cyc - first_cyc); end
    checks++; if (ifa.busy !== 1'b0 || ifa.tx_valid !== 1'b0) begin errors++; $display("FAIL t1_idle_after: busy=%b valid=%b expected 0 0", ifa.busy, ifa.tx_valid); end
    $display("test_value_latency done");
  endtask

  task automatic test_stall();
    logic [7:0] exp_v [0:7];
    exp_v = '{8'h56, 8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0D, 8'h0A};
    ifa.display_val = 16'd65535; ifa.update_display = 1'b1;
    step();
    ifa.update_display = 1'b0;
    collect(0, 8, 1, 100);
    checks++; if (got !== 8) begin errors++; $display("FAIL t2_count: got %0d expected 8", got); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL t2_byte%0d: got %02h expected %02h", i, cap[i], exp_v[i]); end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL t2_hold: %0d hold violations expected 0", viol); end
    $display("test_stall done");
  endtask

  task automatic test_same_edge();
    logic [7:0] exp_e [0:4];
    logic [7:0] exp_v [0:7];
    int ovr_total;
    exp_e = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
    exp_v = '{8'h56, 8'h30, 8'h30, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A};
    step();
    ifa.display_val = 16'd42; ifa.update_display = 1'b1; ifa.show_error = 1'b1;
    step();
    ifa.update_display = 1'b0; ifa.show_error = 1'b0;
    collect(0, 5, 0, 20);
    ovr_total = ovr_cnt;
    checks++; if (got !== 5) begin errors++; $display("FAIL t3_err_count: got %0d expected 5", got); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (cap[i] !== exp_e[i]) begin errors++; $display("FAIL t3_err_byte%0d: got %02h expected %02h", i, cap[i], exp_e[i]); end
    end
    collect(0, 8, 0, 40);
    ovr_total += ovr_cnt;
    checks++; if (got !== 8) begin errors++; $display("FAIL t3_val_count: got %0d expected 8", got); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL t3_val_byte%0d: got %02h expected %02h", i, cap[i], exp_v[i]); end
    end
    checks++; if (ovr_total !== 0) begin errors++; $display("FAIL t3_overrun: got %0d pulses expected 0", ovr_total); end
    $display("test_same_edge done");
  endtask

  task automatic test_overrun();
    logic [7:0] exp_7 [0:7];
    logic [7:0] exp_e [0:4];
    logic [7:0] exp_2 [0:7];
    int waited;
    int ovr_total;
    exp_7 = '{8'h56, 8'h30, 8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A};
    exp_e = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
    exp_2 = '{8'h56, 8'h30, 8'h30, 8'h32, 8'h30, 8'h30, 8'h0D, 8'h0A};
    step();
    ifa.tx_ready = 1'b0;
    ifa.display_val = 16'd7; ifa.update_display = 1'b1;
    step();
    ifa.update_display = 1'b0;
    waited = 0;
    while (ifa.tx_valid !== 1'b1 && waited < 40) begin step(); waited++; end
    checks++; if (ifa.tx_valid !== 1'b1) begin errors++; $display("FAIL t4_frame_start: valid=%b expected 1 within 40 clks", ifa.tx_valid); end
    ifa.display_val = 16'd100; ifa.update_display = 1'b1;
    step();
    checks++; if (ifa.overrun !== 1'b0) begin errors++; $display("FAIL t4_ovr_first: got %b expected 0", ifa.overrun); end
    ifa.display_val = 16'd200;
    step();
    checks++; if (ifa.overrun !== 1'b1) begin errors++; $display("FAIL t4_ovr_second: got %b expected 1", ifa.overrun); end
    ifa.update_display = 1'b0; ifa.show_error = 1'b1;
    step();
    checks++; if (ifa.overrun !== 1'b0) begin errors++; $display("FAIL t4_ovr_error: got %b expected 0", ifa.overrun); end
    ifa.show_error = 1'b0;
    step();
    checks++; if (ifa.tx_valid !== 1'b1 || ifa.tx_data !== 8'h56) begin errors++; $display("FAIL t4_stalled_hold: valid=%b data=%02h expected 1 56", ifa.tx_valid, ifa.tx_data); end
    collect(0, 8, 0, 20);
    ovr_total = ovr_cnt;
    for (int i = 0; i < 8; i++) begin
      checks++; if (cap[i] !== exp_7[i]) begin errors++; $display("FAIL t4_v7_byte%0d: got %02h expected %02h", i, cap[i], exp_7[i]); end
    end
    collect(0, 5, 0, 20);
    ovr_total += ovr_cnt;
    checks++; if (got !== 5) begin errors++; $display("FAIL t4_err_count: got %0d expected 5", got); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (cap[i] !== exp_e[i]) begin errors++; $display("FAIL t4_err_byte%0d: got %02h expected %02h", i, cap[i], exp_e[i]); end
    end
    collect(0, 8, 0, 40);
    ovr_total += ovr_cnt;
    checks++; if (got !== 8) begin errors++; $display("FAIL t4_v200_count: got %0d expected 8", got); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (cap[i] !== exp_2[i]) begin errors++; $display("FAIL t4_v200_byte%0d: got %02h expected %02h", i, cap[i], exp_2[i]); end
    end
    checks++; if (ovr_total !== 0) begin errors++; $display("FAIL t4_ovr_extra: got %0d extra pulses expected 0", ovr_total); end
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid_frame();
    int activity;
    step();
    ifa.display_val = 16'd12345; ifa.update_display = 1'b1;
    step();
    ifa.update_display = 1'b0;
    repeat (3) step();
    ifa.show_error = 1'b1;
    step();
    ifa.show_error = 1'b0;
    collect(0, 2, 0, 40);
    checks++; if (ifa.tx_valid !== 1'b1 || ifa.tx_data !== 8'h32) begin errors++; $display("FAIL t5_third_byte: valid=%b data=%02h expected 1 32", ifa.tx_valid, ifa.tx_data); end
    ifa.tx_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (ifa.tx_valid !== 1'b0) begin errors++; $display("FAIL t5_valid_async: got %b expected 0", ifa.tx_valid); end
    checks++; if (ifa.busy !== 1'b0 || ifa.tx_data !== 8'h00) begin errors++; $display("FAIL t5_clear: busy=%b data=%02h expected 0 00", ifa.busy, ifa.tx_data); end
    repeat (2) step();
    #3 reset_n = 1'b1;
    ifa.tx_ready = 1'b1;
    activity = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ifa.tx_valid || ifa.busy) activity++;
    end
    checks++; if (activity !== 0) begin errors++; $display("FAIL t5_after_reset: %0d active cycles expected 0", activity); end
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_no_crlf();
    logic [7:0] exp_v [0:5];
    logic [7:0] exp_e [0:2];
    int extra;
    exp_v = '{8'h56, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
    exp_e = '{8'h45, 8'h52, 8'h52};
    ifb.display_val = 16'd0; ifb.update_display = 1'b1;
    step();
    ifb.update_display = 1'b0;
    collect(1, 6, 0, 40);
    checks++; if (got !== 6) begin errors++; $display("FAIL t6_val_count: got %0d expected 6", got); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap[i] !== exp_v[i]) begin errors++; $display("FAIL t6_val_byte%0d: got %02h expected %02h", i, cap[i], exp_v[i]); end
    end
    checks++; if (ifb.busy !== 1'b0) begin errors++; $display("FAIL t6_val_busy: got %b expected 0", ifb.busy); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (ifb.tx_valid) extra++;
      step();
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL t6_val_extra: %0d extra valid cycles expected 0", extra); end
    ifb.show_error = 1'b1;
    step();
    ifb.show_error = 1'b0;
    collect(1, 3, 0, 20);
    checks++; if (got !== 3) begin errors++; $display("FAIL t6_err_count: got %0d expected 3", got); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (cap[i] !== exp_e[i]) begin errors++; $display("FAIL t6_err_byte%0d: got %02h expected %02h", i, cap[i], exp_e[i]); end
    end
    checks++; if (ifb.busy !== 1'b0 || ifb.tx_valid !== 1'b0) begin errors++; $display("FAIL t6_err_idle: busy=%b valid=%b expected 0 0", ifb.busy, ifb.tx_valid); end
    $display("test_no_crlf done");
  endtask

  initial begin
    ifa.display_val = '0; ifa.update_display = 1'b0; ifa.show_error = 1'b0; ifa.tx_ready = 1'b0;
    ifb.display_val = '0; ifb.update_display = 1'b0; ifb.show_error = 1'b0; ifb.tx_ready = 1'b0;
    test_reset();
    test_value_latency();
    test_stall();
    test_same_edge();
    test_overrun();
    test_reset_mid_frame();
    test_no_crlf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
